addtree_driver: RTL and testbench

//  Hardware stimulus/checker for the addtree block: the driving end of its a/b/c/d -> q interface.
//  - Generates NVEC pseudo-random operand sets from a 64-bit LFSR.
//  - Drives the sets into a DUT and samples q LAT cycles later.
//  - Compares q with a locally computed a+b+c+d and keeps pass/fail counts.
//  - Used for on-board/self-test of addtree variants with different pipeline depths.

---
 rtl/addtree_driver.sv | 169 ++++++++++++++++
 tb/tb_addtree_driver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/addtree_driver.sv
// Self-test driver for an addtree DUT: issues LFSR-derived operand sets on a..d,
// then checks q LAT cycles later against a locally delayed a+b+c+d.
module addtree_driver #(
  parameter int          WIDTH = 64,
  parameter int          LAT   = 1,
  parameter int          NVEC  = 100,
  parameter logic [63:0] SEED  = 64'h1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      fail_cnt,
  output logic             err,
  output logic [15:0]      first_fail_idx
);

  localparam logic [63:0] SEED_EFF   = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam logic [15:0] LAST_IDX   = 16'(NVEC - 1);
  localparam logic [3:0]  DRAIN_LAST = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
  } vec_t;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic vec_t make_vec(input logic [63:0] s, input logic [15:0] k);
    vec_t        v;
    logic [63:0] rot, inv, kz;
    rot = {s[31:0], s[63:32]};
    inv = ~s;
    kz  = {48'h0, k};
    v.a = s[WIDTH-1:0];
    v.b = rot[WIDTH-1:0];
    v.c = inv[WIDTH-1:0];
    v.d = kz[WIDTH-1:0];
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] vec_sum(input vec_t v);
    return v.a + v.b + v.c + v.d;
  endfunction

  state_t      state, state_nxt;
  logic        load, issue;
  logic [63:0] lfsr, lfsr_nxt;
  logic [15:0] idx, idx_nxt;
  logic [3:0]  dcnt;
  vec_t        vec_nxt;

  // Stage 0 holds the vector currently on a..d; stage LAT is what q answers now.
  logic [LAT:0]            vld_pipe;
  logic [LAT:0][WIDTH-1:0] exp_pipe;
  logic [LAT:0][15:0]      idx_pipe;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) state_nxt = (LAT == 0) ? DONE : DRAIN;
        else                 issue     = 1'b1;
      end
      DRAIN: if (dcnt == DRAIN_LAST) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (load) begin
      lfsr_nxt = SEED_EFF;
      idx_nxt  = 16'd0;
    end else begin
      lfsr_nxt = lfsr_step(lfsr);
      idx_nxt  = idx + 16'd1;
    end
    vec_nxt = make_vec(lfsr_nxt, idx_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr           <= SEED_EFF;
      idx            <= 16'd0;
      dcnt           <= 4'd0;
      a              <= '0;
      b              <= '0;
      c              <= '0;
      d              <= '0;
      vld_pipe       <= '0;
      exp_pipe       <= '0;
      idx_pipe       <= '0;
      pass_cnt       <= 16'd0;
      fail_cnt       <= 16'd0;
      err            <= 1'b0;
      first_fail_idx <= 16'hFFFF;
    end else begin
      if (load || issue) begin
        lfsr        <= lfsr_nxt;
        idx         <= idx_nxt;
        a           <= vec_nxt.a;
        b           <= vec_nxt.b;
        c           <= vec_nxt.c;
        d           <= vec_nxt.d;
        vld_pipe[0] <= 1'b1;
        exp_pipe[0] <= vec_sum(vec_nxt);
        idx_pipe[0] <= idx_nxt;
      end else begin
        a           <= '0;
        b           <= '0;
        c           <= '0;
        d           <= '0;
        vld_pipe[0] <= 1'b0;
      end

      for (int i = 1; i <= LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end

      if (state == RUN)        dcnt <= 4'd0;
      else if (state == DRAIN) dcnt <= dcnt + 4'd1;

      if (load) begin
        pass_cnt       <= 16'd0;
        fail_cnt       <= 16'd0;
        err            <= 1'b0;
        first_fail_idx <= 16'hFFFF;
      end else if (vld_pipe[LAT]) begin
        if (q == exp_pipe[LAT]) begin
          pass_cnt <= pass_cnt + 16'd1;
        end else begin
          fail_cnt <= fail_cnt + 16'd1;
          err      <= 1'b1;
          if (first_fail_idx == 16'hFFFF) first_fail_idx <= idx_pipe[LAT];
        end
      end
    end
  end

endmodule

// File: tb/tb_addtree_driver.sv
// Bench for addtree_driver: a registered addtree model (latency/fault selectable)
// behind a LAT=1 driver, and a combinational adder behind a LAT=0 driver.
module tb_addtree_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start1, start2;
  logic [63:0] a1, b1, c1, d1, q1, a2, b2, c2, d2, q2;
  logic        busy1, done1, err1, busy2, done2, err2;
  logic [15:0] pass1, fail1, ffi1, pass2, fail2, ffi2;

  logic        lat2, fault;
  logic [63:0] q1r, q1d;

  int n_tests = 0;
  int n_fail  = 0;
  int bd_viol = 0;

  addtree_driver #(.WIDTH(64), .LAT(1), .NVEC(100), .SEED(64'h1)) u1 (
    .clk(clk), .reset(rst_n), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .q(q1),
    .busy(busy1), .done(done1), .pass_cnt(pass1), .fail_cnt(fail1),
    .err(err1), .first_fail_idx(ffi1));

  // SEED of zero must behave as seed 1
  addtree_driver #(.WIDTH(64), .LAT(0), .NVEC(16), .SEED(64'h0)) u2 (
    .clk(clk), .reset(rst_n), .start(start2),
    .a(a2), .b(b2), .c(c2), .d(d2), .q(q2),
    .busy(busy2), .done(done2), .pass_cnt(pass2), .fail_cnt(fail2),
    .err(err2), .first_fail_idx(ffi2));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1r <= '0;
      q1d <= '0;
    end else begin
      q1r <= (a1 + b1 + c1 + d1) ^ {63'd0, fault && (d1 == 64'd5)};
      q1d <= q1r;
    end
  end
  assign q1 = lat2 ? q1d : q1r;
  assign q2 = a2 + b2 + c2 + d2;

  always @(negedge clk) if ((busy1 && done1) || (busy2 && done2)) bd_viol++;

  function automatic logic [63:0] step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // One run of u1: start, vector-by-vector compare against the spec formula,
  // optional start pulse during RUN, and edge count from E_0 to done.
  task automatic run1(input int pulse_at, output int cyc);
    logic [63:0] s;
    int          vmis;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    check("clr_pass", 64'(pass1), 64'd0);
    check("clr_fail", 64'(fail1), 64'd0);
    check("clr_ffi", 64'(ffi1), 64'hFFFF);
    s    = 64'h1;
    cyc  = 0;
    vmis = 0;
    while (cyc < 500) begin
      if (cyc < 100) begin
        if (a1 !== s || b1 !== {s[31:0], s[63:32]} || c1 !== ~s || d1 !== 64'(cyc))
          vmis++;
        s = step(s);
      end
      if (cyc == 50) check("busy_mid", 64'(busy1), 64'd1);
      start1 = (cyc == pulse_at);
      @(posedge clk);
      #1 cyc++;
      if (done1) break;
    end
    start1 = 1'b0;
    check("vec_seq", 64'(vmis), 64'd0);
  endtask

  typedef struct {
    logic        lat2;
    logic        fault;
    int          pass_lo, pass_hi, fail_lo, fail_hi;
    logic        err;
    logic [15:0] ffi;
  } rec_t;

  rec_t tbl[3];
  int   cyc;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 100, 100, 0, 0, 1'b0, 16'hFFFF};  // golden
    tbl[1] = '{1'b0, 1'b1, 99, 99, 1, 1, 1'b1, 16'd5};       // q[0] flip at vector 5
    tbl[2] = '{1'b1, 1'b0, 0, 5, 95, 100, 1'b1, 16'd0};      // DUT one cycle slower

    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; lat2 = 1'b0; fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", a1, 64'd0);
    check("rst_d", d1, 64'd0);
    check("rst_pass", 64'(pass1), 64'd0);
    check("rst_fail", 64'(fail1), 64'd0);
    check("rst_ffi", 64'(ffi1), 64'hFFFF);
    check("rst_flags", {61'd0, busy1, done1, err1}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // LAT=0 combinational DUT
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    check("t2_a0", a2, 64'h1);
    check("t2_b0", b2, 64'h1_0000_0000);
    check("t2_c0", c2, ~64'h1);
    check("t2_d0", d2, 64'h0);
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (!done2 && cyc < 200);
    check("t2_done_at", 64'(cyc), 64'd16);
    check("t2_pass", 64'(pass2), 64'd16);
    check("t2_fail", 64'(fail2), 64'd0);

    for (int i = 0; i < 3; i++) begin
      lat2  = tbl[i].lat2;
      fault = tbl[i].fault;
      run1(-1, cyc);
      check($sformatf("tbl%0d_done_at", i), 64'(cyc), 64'd101);
      check_rng($sformatf("tbl%0d_pass", i), int'(pass1), tbl[i].pass_lo, tbl[i].pass_hi);
      check_rng($sformatf("tbl%0d_fail", i), int'(fail1), tbl[i].fail_lo, tbl[i].fail_hi);
      check($sformatf("tbl%0d_err", i), 64'(err1), 64'(tbl[i].err));
      check($sformatf("tbl%0d_ffi", i), 64'(ffi1), 64'(tbl[i].ffi));
    end
    lat2 = 1'b0; fault = 1'b0;

    // reset mid-run at vector 40
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("t5_at40", d1, 64'd40);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("t5_rst_ops", a1 | b1 | c1 | d1, 64'd0);
    check("t5_rst_cnt", {32'd0, pass1, fail1}, 64'd0);
    check("t5_rst_flags", {61'd0, busy1, done1, err1}, 64'd0);
    check("t5_rst_ffi", 64'(ffi1), 64'hFFFF);
    @(negedge clk) rst_n = 1'b1;
    run1(-1, cyc);
    check("t5_done_at", 64'(cyc), 64'd101);
    check("t5_pass", 64'(pass1), 64'd100);
    check("t5_fail", 64'(fail1), 64'd0);

    // start during RUN is ignored; start at DONE restarts the same sequence
    run1(50, cyc);
    check("t6_done_at", 64'(cyc), 64'd101);
    check("t6_pass", 64'(pass1), 64'd100);
    run1(-1, cyc);
    check("t6_re_done_at", 64'(cyc), 64'd101);
    check("t6_re_pass", 64'(pass1), 64'd100);
    check("t6_re_ffi", 64'(ffi1), 64'hFFFF);

    check("busy_done_excl", 64'(bd_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
